ch_seq: RTL and testbench

- Per-channel job sequencer for the compression channel buffer. The buffer is a source FIFO into the engine and a destination FIFO out of it.
- Clears the buffer, pushes exactly `dc` 64-bit source words (last word flagged), and signals end-of-input to the engine.
- Drains the destination FIFO until the end-flagged word appears, then reports completion with the output word count.
- Sits between the channel register and descriptor logic and the channel buffer.

---
 rtl/ch_seq_if.sv | 22 ++
 rtl/ch_seq.sv | 185 ++++++++++++++++++
 tb/tb_ch_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ch_seq_if.sv
// rtl/ch_seq_if.sv - channel buffer handshake between ch_seq and the source/destination FIFOs
interface ch_seq_if;
  logic m_reset;
  logic src_start;
  logic src_stop;
  logic src_xfer;
  logic src_last;
  logic m_endn;
  logic dst_start;
  logic dst_end;
  logic dst_xfer;

  modport master (
    output m_reset, src_xfer, src_last, m_endn, dst_xfer,
    input  src_start, src_stop, dst_start, dst_end
  );

  modport slave (
    input  m_reset, src_xfer, src_last, m_endn, dst_xfer,
    output src_start, src_stop, dst_start, dst_end
  );
endinterface

// File: rtl/ch_seq.sv
// rtl/ch_seq.sv - per-channel job sequencer: clear buffer, push dc source words, drain to end word
module ch_seq #(
  parameter int CNT_W   = 24,
  parameter int CLR_CYC = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [CNT_W-1:0] dc,
  ch_seq_if.master         buf_if,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [2:0] {IDLE, CLR, SRC, DRAIN, FIN} state_t;

  localparam logic [3:0]       CLR_LAST = 4'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [3:0]       clr_cnt_q, clr_cnt_d;
  logic             abort_fl_q, abort_fl_d;
  logic             end_seen_q, end_seen_d;
  logic             m_reset_q, m_reset_d;
  logic             src_xfer_q, src_xfer_d;
  logic             src_last_q, src_last_d;
  logic             m_endn_q, m_endn_d;
  logic             dst_xfer_q, dst_xfer_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] rem_eff;
  logic             end_event;

  always_comb begin
    state_d    = state_q;
    out_cnt_d  = out_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    abort_fl_d = abort_fl_q;
    m_reset_d  = m_reset_q;
    m_endn_d   = m_endn_q;
    busy_d     = busy_q;
    err_d      = err_q;
    src_xfer_d = 1'b0;
    src_last_d = 1'b0;
    dst_xfer_d = 1'b0;
    done_d     = 1'b0;

    // Words still to issue once the strobe already in flight is accounted for.
    rem_eff   = rem_q - (src_xfer_q ? ONE : '0);
    rem_d     = rem_eff;
    end_event = end_seen_q | (dst_xfer_q & buf_if.dst_end);
    end_seen_d = end_event;

    if (dst_xfer_q && !buf_if.dst_end && out_cnt_q != '1) begin
      out_cnt_d = out_cnt_q + ONE;
    end

    case (state_q)
      IDLE: begin
        if (go) begin
          out_cnt_d = '0;
          if (dc != '0) begin
            rem_d      = dc;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            m_reset_d  = 1'b1;
            clr_cnt_d  = '0;
            abort_fl_d = 1'b0;
            state_d    = CLR;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      CLR: begin
        if (clr_cnt_q == CLR_LAST) begin
          m_reset_d = 1'b0;
          clr_cnt_d = '0;
          state_d   = abort_fl_q ? FIN : SRC;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      SRC: begin
        if (end_event) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          dst_xfer_d = buf_if.dst_start;
          src_xfer_d = buf_if.src_start & ~buf_if.src_stop & (rem_eff != '0);
          src_last_d = buf_if.src_start & ~buf_if.src_stop & (rem_eff == ONE);
          if (src_xfer_q && src_last_q) begin
            m_endn_d = 1'b0;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (end_event) begin
          state_d = FIN;
        end else begin
          dst_xfer_d = buf_if.dst_start;
        end
      end
      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        m_endn_d   = 1'b1;
        end_seen_d = 1'b0;
        abort_fl_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort always routes through CLR so the FIFOs are flushed before FIN.
    if (abort && state_q != IDLE) begin
      src_xfer_d = 1'b0;
      src_last_d = 1'b0;
      dst_xfer_d = 1'b0;
      m_endn_d   = 1'b1;
      err_d      = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      end_seen_d = 1'b0;
      m_reset_d  = 1'b1;
      clr_cnt_d  = '0;
      abort_fl_d = 1'b1;
      state_d    = CLR;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      out_cnt_q  <= '0;
      clr_cnt_q  <= '0;
      abort_fl_q <= 1'b0;
      end_seen_q <= 1'b0;
      m_reset_q  <= 1'b0;
      src_xfer_q <= 1'b0;
      src_last_q <= 1'b0;
      m_endn_q   <= 1'b1;
      dst_xfer_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      out_cnt_q  <= out_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      abort_fl_q <= abort_fl_d;
      end_seen_q <= end_seen_d;
      m_reset_q  <= m_reset_d;
      src_xfer_q <= src_xfer_d;
      src_last_q <= src_last_d;
      m_endn_q   <= m_endn_d;
      dst_xfer_q <= dst_xfer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign buf_if.m_reset  = m_reset_q;
  assign buf_if.src_xfer = src_xfer_q;
  assign buf_if.src_last = src_last_q;
  assign buf_if.m_endn   = m_endn_q;
  assign buf_if.dst_xfer = dst_xfer_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign out_cnt         = out_cnt_q;

endmodule

// File: tb/tb_ch_seq.sv
// tb/tb_ch_seq.sv - self-checking bench for ch_seq with a queue-based channel buffer model
module tb_ch_seq;
  localparam int CNT_W   = 24;
  localparam int CLR_CYC = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic             abort;
  logic [CNT_W-1:0] dc;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] out_cnt;

  ch_seq_if bus ();

  ch_seq #(.CNT_W(CNT_W), .CLR_CYC(CLR_CYC)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .go       (go),
    .abort    (abort),
    .dc       (dc),
    .buf_if   (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int src_cnt, last_cnt, last_pos, last_cyc, first_src, mrst, endn_cyc;
  int dst_rd, ovr, end_cyc, done_cnt, done_cyc, done_err, done_out, done_busy;
  int go_cyc, bp_left, bp_resume;
  int start_pct, stop_pct, dst_pct;
  int ee_at = -1;
  int bp_at = -1;
  bit ee_armed, force_stop, allow_end, pend_pop, aborted;
  bit dq[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, {bus.m_reset, bus.src_xfer, bus.src_last, bus.m_endn,
                          bus.dst_xfer, busy, done, err}, 8'b0001_0000);
    chk({tag, "_out_cnt"}, out_cnt, 0);
  endtask

  // One clock: observe the cycle's outputs, advance the buffer model, drive next inputs.
  task automatic tick();
    int nxt;
    @(posedge clk);
    #1;
    cyc++;
    if (pend_pop && dq.size() > 0) void'(dq.pop_front());
    if (bus.src_xfer) begin
      src_cnt++;
      if (first_src < 0) first_src = cyc;
    end
    if (bus.src_last) begin
      last_cnt++;
      last_pos = src_cnt;
      last_cyc = cyc;
      if (!bus.src_xfer) last_cnt += 100;
    end
    if (bus.m_reset) mrst++;
    if (!bus.m_endn && endn_cyc < 0) endn_cyc = cyc;
    if (bus.dst_xfer) begin
      dst_rd++;
      if (dq.size() == 0) ovr++;
      else if (dq[0]) end_cyc = cyc;
    end
    pend_pop = bus.dst_xfer;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_err  = int'(err);
      done_out  = int'(out_cnt);
      done_busy = int'(busy);
    end
    if (ee_at >= 0) begin
      if (!ee_armed && src_cnt == ee_at) begin
        ee_armed   = 1'b1;
        force_stop = 1'b1;
        allow_end  = 1'b1;
      end else if (ee_armed && bus.dst_xfer) begin
        force_stop = 1'b0;
      end
    end
    if (bp_at >= 0 && bp_resume < 0) begin
      if (bp_left == 0 && src_cnt >= bp_at) begin
        bp_left    = 20;
        force_stop = 1'b1;
      end else if (bp_left > 0) begin
        bp_left--;
        if (bp_left == 0) begin
          force_stop = 1'b0;
          bp_resume  = src_cnt;
        end
      end
    end
    if (!bus.m_endn) allow_end = 1'b1;
    bus.src_start = ($urandom_range(99) < start_pct);
    bus.src_stop  = force_stop || ($urandom_range(99) < stop_pct);
    nxt = pend_pop ? 1 : 0;
    bus.dst_end = (dq.size() > 0) ? dq[0] : 1'b0;
    if (dq.size() > nxt)
      bus.dst_start = (!dq[nxt] || allow_end) && ($urandom_range(99) < dst_pct);
    else
      bus.dst_start = 1'b0;
  endtask

  task automatic clear_obs();
    src_cnt = 0; last_cnt = 0; last_pos = -1; last_cyc = -1; first_src = -1;
    mrst = 0; endn_cyc = -1; dst_rd = 0; ovr = 0; end_cyc = -1;
    done_cnt = 0; done_cyc = -1; done_err = -1; done_out = -1; done_busy = -1;
    pend_pop = 1'b0; allow_end = 1'b0; ee_armed = 1'b0; force_stop = 1'b0;
    bp_left = 0; bp_resume = -1; aborted = 1'b0;
  endtask

  // ndst non-end words followed by the end word; ndst < 0 means the destination stays empty.
  task automatic run_job(input string tag, input int jdc, input int ndst, input int abort_at);
    clear_obs();
    dq.delete();
    for (int i = 0; i < ndst; i++) dq.push_back(1'b0);
    if (ndst >= 0) dq.push_back(1'b1);
    dc     = CNT_W'(jdc);
    go     = 1'b1;
    go_cyc = cyc;
    tick();
    go = 1'b0;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      if (abort_at >= 0 && !aborted && src_cnt == abort_at) begin
        abort   = 1'b1;
        aborted = 1'b1;
        mrst    = 0;
        tick();
        abort = 1'b0;
      end else begin
        tick();
      end
    end
    chk({tag, "_done_seen"}, done_cnt > 0, 1);
    tick();
    tick();
    chk({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; dc = '0;
    bus.src_start = 1'b0; bus.src_stop = 1'b0; bus.dst_start = 1'b0; bus.dst_end = 1'b0;
    start_pct = 100; stop_pct = 0; dst_pct = 100;
    clear_obs();
    #12;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // Basic job: 5 source words, 3 destination words plus end word.
    run_job("basic", 5, 3, -1);
    chk("basic_go_to_src", first_src - go_cyc, CLR_CYC + 2);
    chk("basic_mreset_cyc", mrst, CLR_CYC);
    chk("basic_src_cnt", src_cnt, 5);
    chk("basic_last_cnt", last_cnt, 1);
    chk("basic_last_pos", last_pos, 5);
    chk("basic_endn_lat", endn_cyc - last_cyc, 1);
    chk("basic_end_to_done", done_cyc - end_cyc, 2);
    chk("basic_out_cnt", done_out, 3);
    chk("basic_err", done_err, 0);
    chk("basic_busy_at_done", done_busy, 0);
    chk("basic_overread", ovr, 0);

    // Randomized jobs: the buffer model gates both FIFOs randomly.
    for (int j = 0; j < 6; j++) begin
      int jdc, nd;
      start_pct = int'($urandom_range(50, 100));
      stop_pct  = int'($urandom_range(0, 40));
      dst_pct   = int'($urandom_range(30, 100));
      jdc = int'($urandom_range(1, 40));
      nd  = int'($urandom_range(0, 12));
      run_job("rand", jdc, nd, -1);
      chk("rand_src_cnt", src_cnt, jdc);
      chk("rand_last_cnt", last_cnt, 1);
      chk("rand_last_pos", last_pos, jdc);
      chk("rand_out_cnt", done_out, nd);
      chk("rand_err", done_err, 0);
      chk("rand_mreset_cyc", mrst, CLR_CYC);
      chk("rand_overread", ovr, 0);
    end
    start_pct = 100; stop_pct = 0; dst_pct = 100;

    // Backpressure: src_stop forced for 20 cycles after 256 writes.
    bp_at = 256;
    run_job("bp", 300, 5, -1);
    bp_at = -1;
    chk("bp_pause_seen", bp_resume >= 256, 1);
    chk("bp_slip", bp_resume <= 257, 1);
    chk("bp_src_cnt", src_cnt, 300);
    chk("bp_last_cnt", last_cnt, 1);
    chk("bp_last_pos", last_pos, 300);
    chk("bp_out_cnt", done_out, 5);
    chk("bp_err", done_err, 0);

    // Zero-length job.
    run_job("zero", 0, -1, -1);
    chk("zero_go_to_done", done_cyc - go_cyc, 2);
    chk("zero_err", done_err, 1);
    chk("zero_mreset", mrst, 0);
    chk("zero_src", src_cnt, 0);
    chk("zero_dst", dst_rd, 0);
    chk("zero_busy", done_busy, 0);

    // Abort during SRC after 10 words, then a normal follow-up job.
    run_job("abort", 50, -1, 10);
    chk("abort_src_slip", src_cnt <= 11, 1);
    chk("abort_no_last", last_cnt, 0);
    chk("abort_mreset_cyc", mrst, CLR_CYC);
    chk("abort_err", done_err, 1);
    chk("abort_busy", done_busy, 0);
    chk("abort_endn_held", endn_cyc, -1);
    run_job("post_abort", 2, 1, -1);
    chk("post_abort_src", src_cnt, 2);
    chk("post_abort_last_pos", last_pos, 2);
    chk("post_abort_err", done_err, 0);
    chk("post_abort_out", done_out, 1);

    // Early end word delivered while 4 source words remain.
    ee_at = 6;
    run_job("early", 10, 0, -1);
    ee_at = -1;
    chk("early_err", done_err, 1);
    chk("early_src_cnt", src_cnt, 6);
    chk("early_no_last", last_cnt, 0);
    chk("early_out_cnt", done_out, 0);
    chk("early_endn_held", endn_cyc, -1);

    // Async reset in DRAIN, then a job after release.
    clear_obs();
    dq.delete();
    dq.push_back(1'b0);
    dq.push_back(1'b0);
    dc = CNT_W'(3);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int n = 0; n < 200 && endn_cyc < 0; n++) tick();
    chk("arst_drain_reached", endn_cyc >= 0, 1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    #3;
    rst_n = 1'b1;
    tick();
    run_job("post_arst", 1, 2, -1);
    chk("post_arst_src", src_cnt, 1);
    chk("post_arst_out", done_out, 2);
    chk("post_arst_err", done_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
